hilo_muldiv_unit: RTL and testbench

//  Multi-cycle MIPS multiply/divide unit that owns the HI/LO register pair.
//  The execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it and reads committed HI/LO for MFHI/MFLO.

---
 rtl/mips_hilo_pkg.sv | 20 ++
 rtl/muldiv_iter_core.sv | 37 +++
 rtl/hilo_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: MIPS funct codes
// and the iteration FSM state encoding.
package mips_hilo_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One unsigned iteration step: shift-add multiply (right shift of {acc,q})
// or restoring divide (left shift of {acc,q}, quotient bit enters q[0]).
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Carry out of the add lands in the top bit and is shifted back into acc.
    assign w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
    assign w_shl  = {i_acc, i_q[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, i_b};
    assign w_ge   = (w_shl >= {1'b0, i_b});

    always_comb begin
        o_acc = '0;
        o_q   = '0;
        if (i_div) begin
            o_acc = w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS HI/LO owner: multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO, with
// committed HI/LO always visible for MFHI/MFLO.
module hilo_muldiv_unit
    import mips_hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_START,
    input  logic [5:0]       IN_FUNCT,
    input  logic [WIDTH-1:0] IN_RS,
    input  logic [WIDTH-1:0] IN_RT,
    input  logic             IN_RD_REQ,
    input  logic             IN_FLUSH,
    output logic             OUT_READY,
    output logic             OUT_BUSY,
    output logic             OUT_DONE,
    output logic             OUT_STALL,
    output logic             OUT_DIVZ,
    output logic [WIDTH-1:0] OUT_HI,
    output logic [WIDTH-1:0] OUT_LO
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;
    logic               r_sa;
    logic               r_dz;
    logic               r_done;
    logic               r_divz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_known;
    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_is_mul = (IN_FUNCT == FN_MULT) || (IN_FUNCT == FN_MULTU);
    assign w_is_div = (IN_FUNCT == FN_DIV)  || (IN_FUNCT == FN_DIVU);
    assign w_signed = (IN_FUNCT == FN_MULT) || (IN_FUNCT == FN_DIV);
    assign w_known  = w_is_mul || w_is_div || (IN_FUNCT == FN_MTHI) || (IN_FUNCT == FN_MTLO);
    // A same-edge flush squashes the start as well.
    assign w_accept = IN_START && w_idle && !IN_FLUSH && w_known;

    assign w_sa    = w_signed && IN_RS[WIDTH-1];
    assign w_sb    = w_signed && IN_RT[WIDTH-1];
    assign w_abs_a = w_sa ? -IN_RS : IN_RS;
    assign w_abs_b = w_sb ? -IN_RT : IN_RT;
    assign w_last  = (r_cnt == CNT_W'(WIDTH-1));

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .i_div (r_state == ST_DIV),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_b   (r_b),
        .o_acc (w_acc_nx),
        .o_q   (w_q_nx)
    );

    // Sign fix-up is applied only to the final step's result at commit.
    assign w_prod     = {w_acc_nx, w_q_nx};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo      = r_neg ? -w_q_nx : w_q_nx;
    assign w_rem      = r_sa  ? -w_acc_nx : w_acc_nx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_sa    <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_divz  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_divz <= 1'b0;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_neg  <= w_sa ^ w_sb;
                        r_sa   <= w_sa;
                        r_dz   <= (IN_RT == '0);
                        if (IN_FUNCT == FN_MTHI) begin
                            r_hi <= IN_RS;
                        end else if (IN_FUNCT == FN_MTLO) begin
                            r_lo <= IN_RS;
                        end else if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_q     <= w_abs_b;
                            r_b     <= w_abs_a;
                        end else begin
                            r_state <= ST_DIV;
                            r_q     <= w_abs_a;
                            r_b     <= w_abs_b;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (IN_FLUSH) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_nx;
                        r_q   <= w_q_nx;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            if (r_state == ST_MUL) begin
                                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                                r_lo <= w_prod_fix[WIDTH-1:0];
                            end else begin
                                // Zero divisor leaves the dividend as remainder.
                                r_hi   <= w_rem;
                                r_lo   <= r_dz ? '1 : w_quo;
                                r_divz <= r_dz;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign OUT_READY = w_idle;
    assign OUT_BUSY  = !w_idle;
    assign OUT_DONE  = r_done;
    assign OUT_STALL = IN_RD_REQ && !w_idle;
    assign OUT_DIVZ  = r_divz;
    assign OUT_HI    = r_hi;
    assign OUT_LO    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO/DIVZ are queued at
// issue from a behavioural model and compared at the DONE pulse.
module tb_hilo_muldiv_unit;
    import mips_hilo_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_START = 1'b0;
    logic [5:0]  IN_FUNCT = '0;
    logic [31:0] IN_RS = '0;
    logic [31:0] IN_RT = '0;
    logic        IN_RD_REQ = 1'b0;
    logic        IN_FLUSH = 1'b0;
    logic        OUT_READY, OUT_BUSY, OUT_DONE, OUT_STALL, OUT_DIVZ;
    logic [31:0] OUT_HI, OUT_LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_START(IN_START), .IN_FUNCT(IN_FUNCT),
        .IN_RS(IN_RS), .IN_RT(IN_RT), .IN_RD_REQ(IN_RD_REQ), .IN_FLUSH(IN_FLUSH),
        .OUT_READY(OUT_READY), .OUT_BUSY(OUT_BUSY), .OUT_DONE(OUT_DONE),
        .OUT_STALL(OUT_STALL), .OUT_DIVZ(OUT_DIVZ), .OUT_HI(OUT_HI), .OUT_LO(OUT_LO)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1);
    end

    function automatic exp_t model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        longint      sa, sb2, sq, sr;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        e.divz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (f)
            FN_MULT:  begin p = 64'(sa * sb2); e.hi = p[63:32]; e.lo = p[31:0]; end
            FN_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.divz = 1'b1;
                end else if (f == FN_DIV) begin
                    sq = sa / sb2; sr = sa % sb2;
                    e.hi = sr[31:0]; e.lo = sq[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        IN_START = 1'b1; IN_FUNCT = f; IN_RS = a; IN_RT = b;
        step();
        IN_START = 1'b0; IN_RS = $urandom; IN_RT = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (OUT_BUSY === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        step(); step();
        n_vec++;
        if ({OUT_HI, OUT_LO} !== 64'd0) begin
            n_err++; $display("FAIL reset_hilo: got %h_%h want 0_0", OUT_HI, OUT_LO);
        end
        n_vec++;
        if ({OUT_BUSY, OUT_DONE, OUT_DIVZ, OUT_STALL, OUT_READY} !== 5'b00001) begin
            n_err++; $display("FAIL reset_flags: got %b want 00001",
                              {OUT_BUSY, OUT_DONE, OUT_DIVZ, OUT_STALL, OUT_READY});
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b);
        int   n;
        exp_t e;
        sb.push_back(model(f, a, b));
        drive(f, a, b);
        wait_idle(n);
        n_vec++;
        if (n != 32) begin n_err++; $display("FAIL %s_latency: got %0d want 32", nm, n); end
        n_vec++;
        if (OUT_DONE !== 1'b1 || OUT_READY !== 1'b1) begin
            n_err++; $display("FAIL %s_done: got done=%b ready=%b want 1 1", nm, OUT_DONE, OUT_READY);
        end
        n_vec++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL %s_sb: scoreboard empty at DONE", nm);
        end else begin
            e = sb.pop_front();
            if (OUT_HI !== e.hi || OUT_LO !== e.lo || OUT_DIVZ !== e.divz) begin
                n_err++;
                $display("FAIL %s_result: got hi=%h lo=%h divz=%b want hi=%h lo=%h divz=%b",
                         nm, OUT_HI, OUT_LO, OUT_DIVZ, e.hi, e.lo, e.divz);
            end
        end
        step();
        n_vec++;
        if (OUT_DONE !== 1'b0) begin n_err++; $display("FAIL %s_pulse: done=%b want 0", nm, OUT_DONE); end
    endtask

    task automatic test_muldiv();
        test_op("mult_neg",  FN_MULT,  32'hFFFF_FFFD, 32'd5);
        n_vec++;
        if (OUT_HI !== 32'hFFFF_FFFF || OUT_LO !== 32'hFFFF_FFF1) begin
            n_err++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffff1", OUT_HI, OUT_LO);
        end
        test_op("multu_big", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_op("divu_100_7", FN_DIVU, 32'd100, 32'd7);
        n_vec++;
        if (OUT_HI !== 32'd2 || OUT_LO !== 32'd14) begin
            n_err++; $display("FAIL divu_const: got %h_%h want 2_e", OUT_HI, OUT_LO);
        end
        test_op("div_neg",   FN_DIV,   32'hFFFF_FFF9, 32'd2);
        test_op("div_ovf",   FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        n_vec++;
        if (OUT_HI !== 32'd0 || OUT_LO !== 32'h8000_0000) begin
            n_err++; $display("FAIL div_ovf_const: got %h_%h want 0_80000000", OUT_HI, OUT_LO);
        end
        test_op("divu_z",    FN_DIVU,  32'd5, 32'd0);
        test_op("div_z_neg", FN_DIV,   32'hFFFF_FFF7, 32'd0);
        drive(FN_MTLO, 32'h0000_0001, 32'd0);
        n_vec++;
        if (OUT_DIVZ !== 1'b0) begin n_err++; $display("FAIL divz_clear: got %b want 0", OUT_DIVZ); end
    endtask

    task automatic test_mtx();
        drive(FN_MTHI, 32'h1234_5678, 32'd0);
        n_vec++;
        if (OUT_HI !== 32'h1234_5678 || OUT_BUSY !== 1'b0 || OUT_DONE !== 1'b0) begin
            n_err++; $display("FAIL mthi: got hi=%h busy=%b done=%b want 12345678 0 0", OUT_HI, OUT_BUSY, OUT_DONE);
        end
        drive(FN_MTLO, 32'h9ABC_DEF0, 32'd0);
        n_vec++;
        if (OUT_LO !== 32'h9ABC_DEF0 || OUT_HI !== 32'h1234_5678) begin
            n_err++; $display("FAIL mtlo: got %h_%h want 12345678_9abcdef0", OUT_HI, OUT_LO);
        end
        drive(6'h20, 32'hDEAD_BEEF, 32'd3);
        step();
        n_vec++;
        if (OUT_HI !== 32'h1234_5678 || OUT_LO !== 32'h9ABC_DEF0 || OUT_BUSY !== 1'b0 || OUT_DONE !== 1'b0) begin
            n_err++; $display("FAIL unknown_funct: got %h_%h busy=%b done=%b want unchanged idle",
                              OUT_HI, OUT_LO, OUT_BUSY, OUT_DONE);
        end
    endtask

    task automatic test_ignore_busy();
        int   n;
        exp_t e;
        sb.push_back(model(FN_MULTU, 32'h0001_0003, 32'h0003_0007));
        drive(FN_MULTU, 32'h0001_0003, 32'h0003_0007);
        repeat (9) step();
        IN_RD_REQ = 1'b1;
        #1;
        n_vec++;
        if (OUT_STALL !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b want 1", OUT_STALL); end
        drive(FN_MTHI, 32'h0000_1234, 32'd0);
        drive(FN_MULT, 32'd3, 32'd3);
        IN_RD_REQ = 1'b0;
        wait_idle(n);
        n_vec++;
        if (n != 21) begin n_err++; $display("FAIL ignore_latency: got %0d want 21", n); end
        n_vec++;
        if (sb.size() == 0 || OUT_DONE !== 1'b1) begin
            n_err++; $display("FAIL ignore_done: done=%b sb=%0d want 1 1", OUT_DONE, sb.size());
        end else begin
            e = sb.pop_front();
            if (OUT_HI !== e.hi || OUT_LO !== e.lo) begin
                n_err++; $display("FAIL ignore_result: got %h_%h want %h_%h", OUT_HI, OUT_LO, e.hi, e.lo);
            end
        end
        repeat (3) step();
        n_vec++;
        if (OUT_BUSY !== 1'b0 || OUT_DONE !== 1'b0) begin
            n_err++; $display("FAIL ignore_noqueue: busy=%b done=%b want 0 0", OUT_BUSY, OUT_DONE);
        end
    endtask

    task automatic test_flush();
        int dones;
        drive(FN_MTHI, 32'd0, 32'd0);
        drive(FN_MTLO, 32'h0000_ABCD, 32'd0);
        drive(FN_MULT, 32'd3, 32'd3);
        repeat (3) step();
        IN_FLUSH = 1'b1;
        step();
        IN_FLUSH = 1'b0;
        n_vec++;
        if (OUT_BUSY !== 1'b0 || OUT_READY !== 1'b1) begin
            n_err++; $display("FAIL flush_idle: busy=%b ready=%b want 0 1", OUT_BUSY, OUT_READY);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (OUT_DONE === 1'b1) dones++;
            step();
        end
        n_vec++;
        if (dones != 0 || OUT_HI !== 32'd0 || OUT_LO !== 32'h0000_ABCD) begin
            n_err++; $display("FAIL flush_result: dones=%0d hilo=%h_%h want 0 0_abcd", dones, OUT_HI, OUT_LO);
        end
        IN_FLUSH = 1'b1;
        drive(FN_MTLO, 32'h5555_5555, 32'd0);
        drive(FN_MULTU, 32'd7, 32'd7);
        IN_FLUSH = 1'b0;
        n_vec++;
        if (OUT_BUSY !== 1'b0 || OUT_LO !== 32'h0000_ABCD) begin
            n_err++; $display("FAIL flush_start_drop: busy=%b lo=%h want 0 abcd", OUT_BUSY, OUT_LO);
        end
    endtask

    task automatic test_reset_mid();
        drive(FN_MTLO, 32'h0000_0055, 32'd0);
        drive(FN_DIVU, 32'd1000, 32'd3);
        repeat (19) step();
        IN_RD_REQ = 1'b1;
        RST_N = 1'b0;
        #1;
        n_vec++;
        if ({OUT_HI, OUT_LO} !== 64'd0 || {OUT_BUSY, OUT_DONE, OUT_DIVZ, OUT_STALL} !== 4'b0000) begin
            n_err++; $display("FAIL reset_mid: hilo=%h_%h flags=%b want 0 0000",
                              OUT_HI, OUT_LO, {OUT_BUSY, OUT_DONE, OUT_DIVZ, OUT_STALL});
        end
        IN_RD_REQ = 1'b0;
        #2 RST_N = 1'b1;
        step();
        test_op("post_rst_multu", FN_MULTU, 32'd2, 32'd3);
        n_vec++;
        if (OUT_LO !== 32'd6 || OUT_HI !== 32'd0) begin
            n_err++; $display("FAIL post_rst_const: got %h_%h want 0_6", OUT_HI, OUT_LO);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fl [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        int          n;
        exp_t        e;
        fl[0] = FN_MULT; fl[1] = FN_MULTU; fl[2] = FN_DIV; fl[3] = FN_DIVU;
        f = fl[0]; a = $urandom; b = $urandom;
        sb.push_back(model(f, a, b));
        drive(f, a, b);
        for (int i = 0; i < 8; i++) begin
            wait_idle(n);
            n_vec++;
            if (n != 32 || OUT_DONE !== 1'b1) begin
                n_err++; $display("FAIL b2b_%0d_timing: cycles=%0d done=%b want 32 1", i, n, OUT_DONE);
            end
            n_vec++;
            if (sb.size() == 0) begin
                n_err++; $display("FAIL b2b_%0d_sb: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (OUT_HI !== e.hi || OUT_LO !== e.lo || OUT_DIVZ !== e.divz) begin
                    n_err++;
                    $display("FAIL b2b_%0d_result: got %h_%h divz=%b want %h_%h divz=%b",
                             i, OUT_HI, OUT_LO, OUT_DIVZ, e.hi, e.lo, e.divz);
                end
            end
            if (i < 7) begin
                f = fl[(i + 1) % 4];
                a = $urandom;
                b = (i == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
                sb.push_back(model(f, a, b));
                drive(f, a, b);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_muldiv();
        test_mtx();
        test_ignore_busy();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
